// File: rtl/dmem_dual_responder.sv
// Dual-lane data-memory responder for the A/B memory-stage lanes.
// One shared write port; a same-cycle B store is parked in a skid register.
module dmem_dual_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reqA_valid,
  output logic                  reqA_ready,
  input  logic [ADDR_WIDTH-1:0] reqA_addr,
  input  logic                  reqA_we,
  input  logic [1:0]            reqA_size,
  input  logic                  reqA_unsigned,
  input  logic [DATA_WIDTH-1:0] reqA_wdata,
  output logic                  rspA_valid,
  output logic [DATA_WIDTH-1:0] rspA_rdata,
  output logic                  rspA_err,
  input  logic                  reqB_valid,
  output logic                  reqB_ready,
  input  logic [ADDR_WIDTH-1:0] reqB_addr,
  input  logic                  reqB_we,
  input  logic [1:0]            reqB_size,
  input  logic                  reqB_unsigned,
  input  logic [DATA_WIDTH-1:0] reqB_wdata,
  output logic                  rspB_valid,
  output logic [DATA_WIDTH-1:0] rspB_rdata,
  output logic                  rspB_err
);

  localparam int DW    = DATA_WIDTH;
  localparam int IW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << IW;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BPEND = 1'b1;

  function automatic logic f_err(input logic [1:0] sz,
                                 input logic [1:0] off);
    f_err = (sz == 2'b11)
          | ((sz == 2'b00) & (off != 2'b00))
          | ((sz == 2'b10) & off[0]);
  endfunction

  function automatic logic [3:0] f_be(input logic [1:0] sz,
                                      input logic [1:0] off);
    case (sz)
      2'b00:   f_be = 4'hF;
      2'b01:   f_be = 4'(4'b0001 << off);
      2'b10:   f_be = off[1] ? 4'hC : 4'h3;
      default: f_be = 4'h0;
    endcase
  endfunction

  function automatic logic [DW-1:0] f_rep(input logic [1:0]    sz,
                                          input logic [DW-1:0] wd);
    case (sz)
      2'b01:   f_rep = {4{wd[7:0]}};
      2'b10:   f_rep = {2{wd[15:0]}};
      default: f_rep = wd;
    endcase
  endfunction

  function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] nw,
                                            input logic [3:0]    be);
    for (int i = 0; i < 4; i++)
      f_merge[8*i +: 8] = be[i] ? nw[8*i +: 8] : old[8*i +: 8];
  endfunction

  function automatic logic [DW-1:0] f_ld(input logic [DW-1:0] w,
                                         input logic [1:0]    sz,
                                         input logic [1:0]    off,
                                         input logic          uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b01:   f_ld = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b10:   f_ld = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: f_ld = w;
    endcase
  endfunction

  logic [DW-1:0]         r_mem [DEPTH];
  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_sk_addr;
  logic [1:0]            r_sk_size;
  logic [DW-1:0]         r_sk_wdata;

  logic          r_vA, r_weA, r_errA, r_unsA;
  logic [1:0]    r_szA, r_offA;
  logic [DW-1:0] r_rdA;
  logic          r_vB, r_weB, r_errB, r_unsB;
  logic [1:0]    r_szB, r_offB;
  logic [DW-1:0] r_rdB;

  logic          w_idle, w_dbl, w_accA, w_accB;
  logic          w_errA, w_errB, w_errS, w_fwd;
  logic [IW-1:0] w_idxA, w_idxB;
  logic          w_we;
  logic [IW-1:0] w_widx;
  logic [DW-1:0] w_wdat;
  logic [3:0]    w_be;

  assign w_idle = (r_state == S_IDLE);
  assign w_dbl  = w_idle & reqA_valid & reqA_we
                & reqB_valid & reqB_we;

  assign reqA_ready = w_idle;
  assign reqB_ready = w_idle & ~(reqA_valid & reqA_we
                                 & reqB_valid & reqB_we);

  assign w_accA = reqA_valid & reqA_ready;
  assign w_accB = reqB_valid & reqB_ready;
  assign w_errA = f_err(reqA_size, reqA_addr[1:0]);
  assign w_errB = f_err(reqB_size, reqB_addr[1:0]);
  assign w_errS = f_err(r_sk_size, r_sk_addr[1:0]);
  assign w_idxA = reqA_addr[ADDR_WIDTH-1:2];
  assign w_idxB = reqB_addr[ADDR_WIDTH-1:2];

  // A store and B load to one word: B sees A's bytes merged in
  assign w_fwd = w_accA & reqA_we & ~w_errA
               & w_accB & ~reqB_we & (w_idxA == w_idxB);

  // Single write port: skid store, else A, else B
  always_comb begin
    w_we   = 1'b0;
    w_widx = '0;
    w_wdat = '0;
    w_be   = 4'h0;
    if (!rst) begin
      if (r_state == S_BPEND) begin
        w_we   = ~w_errS;
        w_widx = r_sk_addr[ADDR_WIDTH-1:2];
        w_wdat = f_rep(r_sk_size, r_sk_wdata);
        w_be   = f_be(r_sk_size, r_sk_addr[1:0]);
      end else if (w_accA & reqA_we & ~w_errA) begin
        w_we   = 1'b1;
        w_widx = w_idxA;
        w_wdat = f_rep(reqA_size, reqA_wdata);
        w_be   = f_be(reqA_size, reqA_addr[1:0]);
      end else if (w_accB & reqB_we & ~w_errB) begin
        w_we   = 1'b1;
        w_widx = w_idxB;
        w_wdat = f_rep(reqB_size, reqB_wdata);
        w_be   = f_be(reqB_size, reqB_addr[1:0]);
      end
    end
  end

  // Memory array: byte-masked write, two synchronous read ports
  always_ff @(posedge clk) begin
    if (w_we)
      r_mem[w_widx] <= f_merge(r_mem[w_widx], w_wdat, w_be);
    r_rdA <= r_mem[w_idxA];
    r_rdB <= w_fwd
      ? f_merge(r_mem[w_idxB],
                f_rep(reqA_size, reqA_wdata),
                f_be(reqA_size, reqA_addr[1:0]))
      : r_mem[w_idxB];
  end

  // State, skid register and per-lane response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sk_addr  <= '0;
      r_sk_size  <= 2'b00;
      r_sk_wdata <= '0;
      r_vA       <= 1'b0;
      r_weA      <= 1'b0;
      r_errA     <= 1'b0;
      r_unsA     <= 1'b0;
      r_szA      <= 2'b00;
      r_offA     <= 2'b00;
      r_vB       <= 1'b0;
      r_weB      <= 1'b0;
      r_errB     <= 1'b0;
      r_unsB     <= 1'b0;
      r_szB      <= 2'b00;
      r_offB     <= 2'b00;
    end else begin
      r_vA   <= w_accA;
      r_weA  <= reqA_we;
      r_errA <= w_errA;
      r_unsA <= reqA_unsigned;
      r_szA  <= reqA_size;
      r_offA <= reqA_addr[1:0];
      if (r_state == S_BPEND) begin
        r_state <= S_IDLE;
        r_vB    <= 1'b1;
        r_weB   <= 1'b1;
        r_errB  <= w_errS;
      end else begin
        r_vB   <= w_accB;
        r_weB  <= reqB_we;
        r_errB <= w_errB;
        r_unsB <= reqB_unsigned;
        r_szB  <= reqB_size;
        r_offB <= reqB_addr[1:0];
        if (w_dbl) begin
          r_state    <= S_BPEND;
          r_sk_addr  <= reqB_addr;
          r_sk_size  <= reqB_size;
          r_sk_wdata <= reqB_wdata;
        end
      end
    end
  end

  assign rspA_valid = r_vA;
  assign rspA_err   = r_vA & r_errA;
  assign rspA_rdata = (r_vA & ~r_weA & ~r_errA)
                    ? f_ld(r_rdA, r_szA, r_offA, r_unsA) : '0;

  assign rspB_valid = r_vB;
  assign rspB_err   = r_vB & r_errB;
  assign rspB_rdata = (r_vB & ~r_weB & ~r_errB)
                    ? f_ld(r_rdB, r_szB, r_offB, r_unsB) : '0;

endmodule

// File: tb/tb_dmem_dual_responder.sv
// Bench for dmem_dual_responder: byte-level program-order memory model
// checked every cycle, plus literal checks on the directed vectors.
module tb_dmem_dual_responder;

  logic        clk;
  logic        rst;
  logic        reqA_valid, reqA_ready, reqA_we, reqA_unsigned;
  logic [11:0] reqA_addr;
  logic [1:0]  reqA_size;
  logic [31:0] reqA_wdata;
  logic        rspA_valid, rspA_err;
  logic [31:0] rspA_rdata;
  logic        reqB_valid, reqB_ready, reqB_we, reqB_unsigned;
  logic [11:0] reqB_addr;
  logic [1:0]  reqB_size;
  logic [31:0] reqB_wdata;
  logic        rspB_valid, rspB_err;
  logic [31:0] rspB_rdata;

  dmem_dual_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
    .clk(clk), .rst(rst),
    .reqA_valid(reqA_valid), .reqA_ready(reqA_ready),
    .reqA_addr(reqA_addr), .reqA_we(reqA_we),
    .reqA_size(reqA_size), .reqA_unsigned(reqA_unsigned),
    .reqA_wdata(reqA_wdata), .rspA_valid(rspA_valid),
    .rspA_rdata(rspA_rdata), .rspA_err(rspA_err),
    .reqB_valid(reqB_valid), .reqB_ready(reqB_ready),
    .reqB_addr(reqB_addr), .reqB_we(reqB_we),
    .reqB_size(reqB_size), .reqB_unsigned(reqB_unsigned),
    .reqB_wdata(reqB_wdata), .rspB_valid(rspB_valid),
    .rspB_rdata(rspB_rdata), .rspB_err(rspB_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  logic [7:0]  m [4096];
  logic [32:0] expA [int];
  logic [32:0] expB [int];
  bit          pend = 1'b0;
  logic [1:0]  sk_sz;
  logic [11:0] sk_a;
  logic [31:0] sk_wd;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit misal(input logic [1:0] sz, input int a);
    return (sz == 2'd3) || (sz == 2'd0 && a % 4 != 0)
        || (sz == 2'd2 && a % 2 != 0);
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 4 : (sz == 2'd1) ? 1 : 2;
  endfunction

  task automatic mstore(input logic [1:0] sz, input int a,
                        input logic [31:0] wd);
    if (!misal(sz, a))
      for (int i = 0; i < nbytes(sz); i++) m[a+i] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] mload(input logic [1:0] sz,
                                        input bit un, input int a);
    logic [31:0] v;
    int n;
    v = 32'h0;
    if (misal(sz, a)) return v;
    n = nbytes(sz);
    for (int i = 0; i < n; i++) v[8*i +: 8] = m[a+i];
    if (!un && n == 1 && v[7])  v = v | 32'hFFFFFF00;
    if (!un && n == 2 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic mop(input bit lane, input bit we, input logic [1:0] sz,
                     input bit un, input int a, input logic [31:0] wd);
    logic [32:0] e;
    if (we) begin
      mstore(sz, a, wd);
      e = {misal(sz, a), 32'h0};
    end else begin
      e = {misal(sz, a), mload(sz, un, a)};
    end
    if (lane) expB[cyc+1] = e;
    else      expA[cyc+1] = e;
  endtask

  task automatic set_a(input bit we, input logic [1:0] sz, input bit un,
                       input logic [11:0] a, input logic [31:0] wd);
    reqA_valid = 1'b1; reqA_we = we; reqA_size = sz;
    reqA_unsigned = un; reqA_addr = a; reqA_wdata = wd;
  endtask

  task automatic set_b(input bit we, input logic [1:0] sz, input bit un,
                       input logic [11:0] a, input logic [31:0] wd);
    reqB_valid = 1'b1; reqB_we = we; reqB_size = sz;
    reqB_unsigned = un; reqB_addr = a; reqB_wdata = wd;
  endtask

  // Drive one cycle of requests, update the model, step to next negedge
  task automatic go(input bit r = 1'b0);
    bit dbl;
    rst = r;
    dbl = reqA_valid & reqA_we & reqB_valid & reqB_we;
    #1;
    chk("reqA_ready", reqA_ready, !pend);
    chk("reqB_ready", reqB_ready, !pend && !dbl);
    if (r) begin
      pend = 1'b0;
    end else if (pend) begin
      mstore(sk_sz, sk_a, sk_wd);
      expB[cyc+1] = {misal(sk_sz, sk_a), 32'h0};
      pend = 1'b0;
    end else begin
      if (reqA_valid)
        mop(0, reqA_we, reqA_size, reqA_unsigned, reqA_addr, reqA_wdata);
      if (dbl) begin
        sk_sz = reqB_size; sk_a = reqB_addr; sk_wd = reqB_wdata;
        pend = 1'b1;
      end else if (reqB_valid) begin
        mop(1, reqB_we, reqB_size, reqB_unsigned, reqB_addr, reqB_wdata);
      end
    end
    @(negedge clk);
    reqA_valid = 1'b0;
    reqB_valid = 1'b0;
    rst = 1'b0;
  endtask

  // Every cycle: DUT responses must match the model's schedule
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rspA_valid", rspA_valid, expA.exists(cyc));
      if (expA.exists(cyc)) begin
        chk("rspA_rdata", rspA_rdata, expA[cyc][31:0]);
        chk("rspA_err", rspA_err, expA[cyc][32]);
        expA.delete(cyc);
      end
      chk("rspB_valid", rspB_valid, expB.exists(cyc));
      if (expB.exists(cyc)) begin
        chk("rspB_rdata", rspB_rdata, expB[cyc][31:0]);
        chk("rspB_err", rspB_err, expB[cyc][32]);
        expB.delete(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    reqA_valid = 0; reqA_we = 0; reqA_size = 0; reqA_unsigned = 0;
    reqA_addr = 0; reqA_wdata = 0;
    reqB_valid = 0; reqB_we = 0; reqB_size = 0; reqB_unsigned = 0;
    reqB_addr = 0; reqB_wdata = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst readyA", reqA_ready, 1);
    chk("rst readyB", reqB_ready, 1);
    chk("rst rspA_valid", rspA_valid, 0);
    chk("rst rspB_valid", rspB_valid, 0);
    chk("rst rspA_rdata", rspA_rdata, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // word store then load, lane A
    set_a(1, 2'd0, 0, 12'h010, 32'hDEADBEEF); go();
    set_a(0, 2'd0, 0, 12'h010, 0); go();
    chk("T1 rdA", rspA_rdata, 32'hDEADBEEF);
    chk("T1 errA", rspA_err, 0);

    // double store
    set_a(1, 2'd0, 0, 12'h020, 32'h11111111);
    set_b(1, 2'd0, 0, 12'h024, 32'h22222222);
    go();
    chk("T2 vA T+1", rspA_valid, 1);
    chk("T2 vB T+1", rspB_valid, 0);
    go();
    chk("T2 vB T+2", rspB_valid, 1);
    chk("T2 vA T+2", rspA_valid, 0);
    set_a(0, 2'd0, 0, 12'h020, 0);
    set_b(0, 2'd0, 0, 12'h024, 0);
    go();
    chk("T2 rdA", rspA_rdata, 32'h11111111);
    chk("T2 rdB", rspB_rdata, 32'h22222222);

    // same-word forwarding A store -> B load
    set_a(1, 2'd0, 0, 12'h030, 32'hAABBCCDD); go();
    set_a(1, 2'd1, 0, 12'h031, 32'h00000055);
    set_b(0, 2'd0, 0, 12'h030, 0);
    go();
    chk("T3 fwd rdB", rspB_rdata, 32'hAABB55DD);

    // sign / zero extension
    set_a(1, 2'd0, 0, 12'h040, 32'h0000F080); go();
    set_a(0, 2'd1, 0, 12'h040, 0);
    set_b(0, 2'd2, 1, 12'h040, 0);
    go();
    chk("T4 lb signed", rspA_rdata, 32'hFFFFFF80);
    chk("T4 lhu", rspB_rdata, 32'h0000F080);

    // misaligned
    set_a(1, 2'd0, 0, 12'h042, 32'h99999999); go();
    chk("T5 st errA", rspA_err, 1);
    set_a(0, 2'd0, 0, 12'h040, 0);
    set_b(0, 2'd2, 0, 12'h043, 0);
    go();
    chk("T5 word unchanged", rspA_rdata, 32'h0000F080);
    chk("T5 lh errB", rspB_err, 1);
    chk("T5 lh rdB", rspB_rdata, 0);

    // B store + A load same word: A sees pre-store data
    set_a(0, 2'd0, 0, 12'h030, 0);
    set_b(1, 2'd0, 0, 12'h030, 32'h12345678);
    go();
    chk("T6 pre-store rdA", rspA_rdata, 32'hAABB55DD);
    set_a(0, 2'd0, 0, 12'h030, 0); go();
    chk("T6 post-store rdA", rspA_rdata, 32'h12345678);

    // halfword store at offset 2, signed half / unsigned byte loads
    set_a(1, 2'd0, 0, 12'h050, 32'h0); go();
    set_b(1, 2'd2, 0, 12'h052, 32'h00008001); go();
    set_a(0, 2'd2, 0, 12'h052, 0);
    set_b(0, 2'd1, 1, 12'h053, 0);
    go();
    chk("T7 lh off2", rspA_rdata, 32'hFFFF8001);
    chk("T7 lbu off3", rspB_rdata, 32'h00000080);

    // double store with misaligned B in skid
    set_a(1, 2'd0, 0, 12'h080, 32'h33333333);
    set_b(1, 2'd0, 0, 12'h082, 32'h44444444);
    go(); go();
    chk("T8 skid errB", rspB_err, 1);

    // reset during B_PENDING discards the skid store
    set_a(1, 2'd0, 0, 12'h060, 32'h12345678); go();
    set_a(1, 2'd0, 0, 12'h070, 32'h0BADF00D);
    set_b(1, 2'd0, 0, 12'h060, 32'hCAFEF00D);
    go();
    go(1'b1);
    chk("T9 no rspB", rspB_valid, 0);
    chk("T9 readyA", reqA_ready, 1);
    chk("T9 readyB", reqB_ready, 1);
    go();
    chk("T9 still no rspB", rspB_valid, 0);
    set_a(0, 2'd0, 0, 12'h060, 0);
    set_b(0, 2'd0, 0, 12'h070, 0);
    go();
    chk("T9 B not written", rspA_rdata, 32'h12345678);
    chk("T9 A kept", rspB_rdata, 32'h0BADF00D);

    go(); go();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_dual_responder.md
# dmem_dual_responder

Dual-lane data-memory responder serving the A and B load/store lanes of the dual-issue core's memory stage. It accepts up to two requests per cycle, returns read data with a fixed one-cycle latency, and owns a single physical write port. When both lanes store in the same cycle, lane A is committed first and lane B is parked in a one-entry skid register for the next cycle. Same-cycle accesses to the same word are ordered A before B, matching program order.

## Interface
Parameters:
- DATA_WIDTH, 32, lane data width (fixed at 32 for this block)
- ADDR_WIDTH, 12, byte-address width; memory is 2^ADDR_WIDTH bytes, organised as 32-bit words

Ports (X = A or B, one set per lane):
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- reqX_valid  in  1  request present
- reqX_ready  out  1  request accepted on a rising edge when valid & ready
- reqX_addr  in  ADDR_WIDTH  byte address
- reqX_we  in  1  1 = store, 0 = load
- reqX_size  in  2  00 word, 01 byte, 10 halfword, 11 reserved (treated as misaligned)
- reqX_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0
- reqX_wdata  in  DATA_WIDTH  store data; sub-word stores use the low bits
- rspX_valid  out  1  response for the request accepted in the previous cycle
- rspX_rdata  out  DATA_WIDTH  load data (0 for stores and for errors)
- rspX_err  out  1  misaligned or reserved access

## Operation
- The state machine has two states: IDLE and B_PENDING. Reset enters IDLE.
- **IDLE**
  - reqA_ready = 1.
  - reqB_ready = 1 unless reqA_valid & reqA_we & reqB_valid & reqB_we.
- **IDLE, double store**
  - Lane A's store is committed.
  - Lane B's addr, size and wdata are latched into the skid register, and B's acceptance is recorded internally.
  - Because reqB_ready = 0, the initiator must hold lane B's request for one cycle.
  - Next state is B_PENDING.
- **B_PENDING**
  - reqA_ready = 0 and reqB_ready = 0.
  - The skid store is committed.
  - rspB_valid is raised in the following cycle.
  - Next state is IDLE.
  - The held lane B request is not re-accepted; the recorded acceptance covers it.
- **Alignment**
  - A word access requires addr[1:0] = 00.
  - A halfword access requires addr[0] = 0.
  - A misaligned or size 11 access writes nothing, returns rdata 0 and err 1, and is still accepted and responded to normally.
- **Stores**
  - Byte-enable mask is derived from size and addr[1:0].
  - Byte and halfword data are replicated to the selected lanes.
- **Loads**
  - The word is read synchronously.
  - The byte or halfword is selected by the registered addr[1:0], then sign- or zero-extended.
- **Same-word ordering in one accepted cycle**
  - A store + B load: B returns the post-store data, forwarded with the byte mask merged.
  - B store + A load: A returns the pre-store data.
  - A load + B load: both are served from the two read ports.
- **Responses**
  - rspX_valid = 1 exactly one cycle after acceptance.
  - Store responses carry rdata 0 and err 0 unless misaligned.
- **Reset**
  - All outputs go low, except reqA_ready = 1 and reqB_ready = 1.
  - The skid register is cleared, state returns to IDLE, and any pending B store is discarded.
  - Memory contents are not reset.

## Timing
- Accept-to-response latency is 1 cycle on both lanes.
- The double-store case costs exactly 1 bubble cycle: A's response arrives at T+1 and B's at T+2.
- Throughput is 2 requests/cycle except for double stores.
- Store data is visible to any load accepted in the cycle after the commit edge.
- No combinational path from rsp* to req*; reqX_ready depends only on state and the current reqA/reqB valid and we inputs.
- rst asserted in B_PENDING: the skid store is not committed, and the outputs take reset values at the next edge.

## Test plan
- **Word store then load, lane A:** store 0xDEADBEEF to 0x010; next cycle load 0x010 -> rspA_rdata = 0xDEADBEEF, rspA_err = 0, one cycle after the load is accepted.
- **Double store:**
  - Stimulus: A stores 0x11111111 to 0x020 and B stores 0x22222222 to 0x024 in the same cycle.
  - Required: reqB_ready = 0 in that cycle, state B_PENDING for 1 cycle, rspA_valid at T+1, rspB_valid at T+2, and later loads return both values.
- **Same-word forwarding:** word 0x030 = 0xAABBCCDD; A stores byte 0x55 to 0x031 while B loads word 0x030 -> rspB_rdata = 0xAABB55DD.
- **Sign/zero extension:** word 0x040 = 0x0000F080; load byte signed from 0x040 -> 0xFFFFFF80; load halfword unsigned from 0x040 -> 0x0000F080.
- **Misaligned:** word store to 0x042 -> rspA_err = 1 and word 0x040 is unchanged; halfword load from 0x043 -> rspB_err = 1, rdata 0.
- **Reset mid-operation:** trigger a double store, then assert rst during B_PENDING -> B's store is not written, reqA_ready = reqB_ready = 1 after reset, and no rspB_valid is issued.
